// File: rtl/dmem_arbiter.sv
// dmem_arbiter: cpu/dbg arbiter and access sequencer in front of the data memory.
// Each legal access holds the memory interface for WAIT_CYCLES+1 cycles, then acks once.
module dmem_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_SIZE    = 8192,
    parameter int WAIT_CYCLES = 1,
    parameter int MAX_STARVE  = 4
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_ack,
    output logic                  cpu_stall,

    input  logic                  dbg_req,
    input  logic                  dbg_we,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    input  logic [DATA_WIDTH-1:0] dbg_wdata,
    output logic [DATA_WIDTH-1:0] dbg_rdata,
    output logic                  dbg_ack,

    output logic                  err,

    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    output logic                  mem_read,
    output logic                  mem_write,
    input  logic [DATA_WIDTH-1:0] mem_read_data
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_WORD  = ADDR_WIDTH'(MEM_SIZE - 4);
    localparam logic [3:0]            CNT_INIT   = 4'(WAIT_CYCLES);
    localparam logic [3:0]            STARVE_MAX = 4'(MAX_STARVE);

    state_t                state;
    state_t                state_nxt;
    logic [3:0]            cnt;
    logic [3:0]            cnt_nxt;
    logic [3:0]            starve;
    logic [3:0]            starve_nxt;
    logic                  lat_we;
    logic                  lat_we_nxt;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [ADDR_WIDTH-1:0] lat_addr_nxt;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic [DATA_WIDTH-1:0] lat_wdata_nxt;
    logic                  win_dbg;
    logic                  win_dbg_nxt;
    logic                  err_pending;
    logic                  err_pending_nxt;
    logic [DATA_WIDTH-1:0] cpu_rdata_q;
    logic [DATA_WIDTH-1:0] cpu_rdata_nxt;
    logic [DATA_WIDTH-1:0] dbg_rdata_q;
    logic [DATA_WIDTH-1:0] dbg_rdata_nxt;

    logic                  grant_dbg;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  sel_bad;
    logic [DATA_WIDTH-1:0] capture;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            starve      <= '0;
            lat_we      <= 1'b0;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            win_dbg     <= 1'b0;
            err_pending <= 1'b0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            starve      <= starve_nxt;
            lat_we      <= lat_we_nxt;
            lat_addr    <= lat_addr_nxt;
            lat_wdata   <= lat_wdata_nxt;
            win_dbg     <= win_dbg_nxt;
            err_pending <= err_pending_nxt;
            cpu_rdata_q <= cpu_rdata_nxt;
            dbg_rdata_q <= dbg_rdata_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        cnt_nxt         = cnt;
        starve_nxt      = starve;
        lat_we_nxt      = lat_we;
        lat_addr_nxt    = lat_addr;
        lat_wdata_nxt   = lat_wdata;
        win_dbg_nxt     = win_dbg;
        err_pending_nxt = err_pending;
        cpu_rdata_nxt   = cpu_rdata_q;
        dbg_rdata_nxt   = dbg_rdata_q;

        // cpu has priority unless dbg has waited MAX_STARVE cpu grants
        grant_dbg = dbg_req & (~cpu_req | (starve == STARVE_MAX));
        sel_we    = grant_dbg ? dbg_we    : cpu_we;
        sel_addr  = grant_dbg ? dbg_addr  : cpu_addr;
        sel_wdata = grant_dbg ? dbg_wdata : cpu_wdata;
        sel_bad   = (sel_addr[1:0] != 2'b00) | (sel_addr > LAST_WORD);
        capture   = lat_we ? '0 : mem_read_data;

        unique case (state)
            IDLE: begin
                if (!dbg_req) begin
                    starve_nxt = '0;
                end
                if (cpu_req || dbg_req) begin
                    lat_we_nxt    = sel_we;
                    lat_addr_nxt  = sel_addr;
                    lat_wdata_nxt = sel_wdata;
                    win_dbg_nxt   = grant_dbg;
                    if (grant_dbg) begin
                        starve_nxt = '0;
                    end else if (dbg_req) begin
                        starve_nxt = starve + 4'd1;
                    end
                    if (sel_bad) begin
                        err_pending_nxt = 1'b1;
                        state_nxt       = DONE;
                        if (grant_dbg) begin
                            dbg_rdata_nxt = '0;
                        end else begin
                            cpu_rdata_nxt = '0;
                        end
                    end else begin
                        err_pending_nxt = 1'b0;
                        cnt_nxt         = CNT_INIT;
                        state_nxt       = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (cnt == 4'd0) begin
                    state_nxt = DONE;
                    if (win_dbg) begin
                        dbg_rdata_nxt = capture;
                    end else begin
                        cpu_rdata_nxt = capture;
                    end
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign mem_address    = (state == ACCESS) ? lat_addr  : '0;
    assign mem_write_data = (state == ACCESS) ? lat_wdata : '0;
    assign mem_read       = (state == ACCESS) & ~lat_we;
    assign mem_write      = (state == ACCESS) & lat_we;

    assign cpu_ack   = (state == DONE) & ~win_dbg;
    assign dbg_ack   = (state == DONE) & win_dbg;
    assign err       = (state == DONE) & err_pending;
    assign cpu_stall = cpu_req & ~cpu_ack;
    assign cpu_rdata = cpu_rdata_q;
    assign dbg_rdata = dbg_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter.
// Instance 0 uses WAIT_CYCLES=1 with a word memory; instances 1/2 use 0 and 3.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_clr;

    logic        cpu_req   [3];
    logic        cpu_we    [3];
    logic [31:0] cpu_addr  [3];
    logic [31:0] cpu_wdata [3];
    logic [31:0] cpu_rdata [3];
    logic        cpu_ack   [3];
    logic        cpu_stall [3];
    logic        dbg_req   [3];
    logic        dbg_we    [3];
    logic [31:0] dbg_addr  [3];
    logic [31:0] dbg_wdata [3];
    logic [31:0] dbg_rdata [3];
    logic        dbg_ack   [3];
    logic        err       [3];
    logic [31:0] mem_address    [3];
    logic [31:0] mem_write_data [3];
    logic        mem_read       [3];
    logic        mem_write      [3];
    logic [31:0] mem_read_data  [3];

    int checks = 0;
    int errors = 0;
    int rd_cyc [3];
    int wr_cyc [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int W = (g == 0) ? 1 : ((g == 1) ? 0 : 3);
        dmem_arbiter #(
            .ADDR_WIDTH (32),
            .DATA_WIDTH (32),
            .MEM_SIZE   (8192),
            .WAIT_CYCLES(W),
            .MAX_STARVE (4)
        ) dut (
            .clk           (clk),
            .rst           (rst),
            .cpu_req       (cpu_req[g]),
            .cpu_we        (cpu_we[g]),
            .cpu_addr      (cpu_addr[g]),
            .cpu_wdata     (cpu_wdata[g]),
            .cpu_rdata     (cpu_rdata[g]),
            .cpu_ack       (cpu_ack[g]),
            .cpu_stall     (cpu_stall[g]),
            .dbg_req       (dbg_req[g]),
            .dbg_we        (dbg_we[g]),
            .dbg_addr      (dbg_addr[g]),
            .dbg_wdata     (dbg_wdata[g]),
            .dbg_rdata     (dbg_rdata[g]),
            .dbg_ack       (dbg_ack[g]),
            .err           (err[g]),
            .mem_address   (mem_address[g]),
            .mem_write_data(mem_write_data[g]),
            .mem_read      (mem_read[g]),
            .mem_write     (mem_write[g]),
            .mem_read_data (mem_read_data[g])
        );
    end

    // Word memory for instance 0; unwritten words read as 0xA5A5_0000 | byte address.
    logic [31:0]   mem [0:2047];
    logic [2047:0] written;
    logic [10:0]   idx0;

    assign idx0 = mem_address[0][12:2];

    always @(posedge clk or posedge mem_clr) begin
        if (mem_clr) begin
            written <= '0;
        end else if (mem_write[0] === 1'b1) begin
            mem[idx0]     <= mem_write_data[0];
            written[idx0] <= 1'b1;
        end
    end

    assign mem_read_data[0] = !mem_read[0] ? 32'h0 :
        (written[idx0] ? mem[idx0] : (32'hA5A5_0000 | {19'b0, idx0, 2'b00}));
    assign mem_read_data[1] = mem_read[1] ? (32'hA5A5_0000 | mem_address[1]) : 32'h0;
    assign mem_read_data[2] = mem_read[2] ? (32'hA5A5_0000 | mem_address[2]) : 32'h0;

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (mem_read[k] === 1'b1) rd_cyc[k] <= rd_cyc[k] + 1;
            if (mem_write[k] === 1'b1) wr_cyc[k] <= wr_cyc[k] + 1;
        end
    end

    // One access on port p (0 cpu, 1 dbg) of instance k; returns observed values.
    task automatic do_access(input int k, input bit p, input logic we,
                             input logic [31:0] a, input logic [31:0] d,
                             output int lat, output logic [31:0] rd,
                             output logic e, output bit stall_bad,
                             output int rdc, output int wrc);
        int   r0;
        int   w0;
        logic ack;
        lat       = -1;
        rd        = 'x;
        e         = 'x;
        stall_bad = 1'b0;
        r0        = rd_cyc[k];
        w0        = wr_cyc[k];
        @(posedge clk);
        #1;
        if (p == 1'b0) begin
            cpu_req[k] = 1'b1; cpu_we[k] = we; cpu_addr[k] = a; cpu_wdata[k] = d;
        end else begin
            dbg_req[k] = 1'b1; dbg_we[k] = we; dbg_addr[k] = a; dbg_wdata[k] = d;
        end
        @(posedge clk);
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            ack = p ? dbg_ack[k] : cpu_ack[k];
            if (ack === 1'b1) begin
                lat = n;
                rd  = p ? dbg_rdata[k] : cpu_rdata[k];
                e   = err[k];
                if (p == 1'b0 && cpu_stall[k] !== 1'b0) stall_bad = 1'b1;
                break;
            end
            if (p == 1'b0 && cpu_stall[k] !== 1'b1) stall_bad = 1'b1;
            @(posedge clk);
        end
        cpu_req[k] = 1'b0;
        dbg_req[k] = 1'b0;
        rdc = rd_cyc[k] - r0;
        wrc = wr_cyc[k] - w0;
    endtask

    task automatic test_reset();
        int          lat;
        logic [31:0] rd;
        logic        e;
        bit          sb;
        int          rdc;
        int          wrc;
        bit          acked;
        #12;
        mem_clr = 1'b0;
        checks++;
        if ({cpu_ack[0], dbg_ack[0], err[0], mem_read[0], mem_write[0]} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 00000",
                     {cpu_ack[0], dbg_ack[0], err[0], mem_read[0], mem_write[0]});
        end
        checks++;
        if ({cpu_rdata[0], dbg_rdata[0], mem_address[0], mem_write_data[0]} !== 128'h0) begin
            errors++;
            $display("FAIL reset_data: got %h %h %h %h expected all 0",
                     cpu_rdata[0], dbg_rdata[0], mem_address[0], mem_write_data[0]);
        end
        cpu_req[0] = 1'b1;
        #1;
        checks++;
        if (cpu_stall[0] !== 1'b1) begin
            errors++;
            $display("FAIL reset_stall_hi: got %b expected 1", cpu_stall[0]);
        end
        cpu_req[0] = 1'b0;
        #1;
        checks++;
        if (cpu_stall[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_stall_lo: got %b expected 0", cpu_stall[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        cpu_req[0] = 1'b1; cpu_we[0] = 1'b1;
        cpu_addr[0] = 32'h10; cpu_wdata[0] = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        checks++;
        if (mem_write[0] !== 1'b1 || mem_address[0] !== 32'h10) begin
            errors++;
            $display("FAIL pre_reset_write: got we=%b addr=%h expected we=1 addr=00000010",
                     mem_write[0], mem_address[0]);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if ({mem_write[0], mem_read[0], cpu_ack[0], err[0]} !== 4'b0 ||
            mem_address[0] !== 32'h0 || mem_write_data[0] !== 32'h0) begin
            errors++;
            $display("FAIL mid_access_reset: got w=%b r=%b ack=%b err=%b a=%h d=%h expected all 0",
                     mem_write[0], mem_read[0], cpu_ack[0], err[0],
                     mem_address[0], mem_write_data[0]);
        end
        cpu_req[0] = 1'b0; cpu_we[0] = 1'b0; cpu_wdata[0] = 32'h0;
        acked = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (cpu_ack[0] !== 1'b0) acked = 1'b1;
        end
        rst = 1'b0;
        checks++;
        if (acked) begin
            errors++;
            $display("FAIL reset_no_ack: got ack=1 expected 0");
        end
        do_access(0, 1'b0, 1'b0, 32'h10, 32'h0, lat, rd, e, sb, rdc, wrc);
        checks++;
        if (lat !== 3 || rd !== 32'hA5A5_0010 || e !== 1'b0) begin
            errors++;
            $display("FAIL reset_reload: got lat=%0d rd=%h err=%b expected lat=3 rd=a5a50010 err=0",
                     lat, rd, e);
        end
    endtask

    task automatic test_store_load();
        int          lat;
        logic [31:0] rd;
        logic        e;
        bit          sb;
        int          rdc;
        int          wrc;
        do_access(0, 1'b0, 1'b1, 32'h20, 32'hDEAD_BEEF, lat, rd, e, sb, rdc, wrc);
        checks++;
        if (lat !== 3 || e !== 1'b0 || rd !== 32'h0) begin
            errors++;
            $display("FAIL store_ack: got lat=%0d err=%b rd=%h expected lat=3 err=0 rd=0",
                     lat, e, rd);
        end
        checks++;
        if (sb || wrc !== 2 || rdc !== 0) begin
            errors++;
            $display("FAIL store_bus: got stall_bad=%0d wr=%0d rd=%0d expected 0 2 0",
                     sb, wrc, rdc);
        end
        do_access(0, 1'b0, 1'b0, 32'h20, 32'h0, lat, rd, e, sb, rdc, wrc);
        checks++;
        if (lat !== 3 || e !== 1'b0 || rd !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL load_ack: got lat=%0d err=%b rd=%h expected lat=3 err=0 rd=deadbeef",
                     lat, e, rd);
        end
        checks++;
        if (sb || rdc !== 2 || wrc !== 0) begin
            errors++;
            $display("FAIL load_bus: got stall_bad=%0d rd=%0d wr=%0d expected 0 2 0",
                     sb, rdc, wrc);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (cpu_rdata[0] !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL rdata_hold: got %h expected deadbeef", cpu_rdata[0]);
        end
    endtask

    task automatic test_simultaneous();
        int cpu_lat = -1;
        int dbg_lat = -1;
        bit both    = 1'b0;
        @(posedge clk);
        #1;
        cpu_req[0] = 1'b1; cpu_we[0] = 1'b0; cpu_addr[0] = 32'h20;
        dbg_req[0] = 1'b1; dbg_we[0] = 1'b0; dbg_addr[0] = 32'h40;
        @(posedge clk);
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (cpu_ack[0] === 1'b1 && dbg_ack[0] === 1'b1) both = 1'b1;
            if (cpu_ack[0] === 1'b1) begin
                cpu_lat = n;
                cpu_req[0] = 1'b0;
                checks++;
                if (cpu_rdata[0] !== 32'hDEAD_BEEF) begin
                    errors++;
                    $display("FAIL simul_cpu_rdata: got %h expected deadbeef", cpu_rdata[0]);
                end
            end
            if (dbg_ack[0] === 1'b1) begin
                dbg_lat = n;
                dbg_req[0] = 1'b0;
                checks++;
                if (dbg_rdata[0] !== 32'hA5A5_0040) begin
                    errors++;
                    $display("FAIL simul_dbg_rdata: got %h expected a5a50040", dbg_rdata[0]);
                end
            end
            if (dbg_lat > 0) break;
            @(posedge clk);
        end
        cpu_req[0] = 1'b0;
        dbg_req[0] = 1'b0;
        checks++;
        if (cpu_lat !== 3 || dbg_lat !== 7 || both) begin
            errors++;
            $display("FAIL simul_order: got cpu=%0d dbg=%0d overlap=%0d expected 3 7 0",
                     cpu_lat, dbg_lat, both);
        end
    endtask

    task automatic test_starvation();
        logic [6:0] got     = 7'h7F;
        int         nacks   = 0;
        int         ncpu    = 0;
        int         dbg_cyc = -1;
        @(posedge clk);
        #1;
        cpu_req[0] = 1'b1; cpu_we[0] = 1'b0; cpu_addr[0] = 32'h20;
        dbg_req[0] = 1'b1; dbg_we[0] = 1'b0; dbg_addr[0] = 32'h44;
        @(posedge clk);
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (cpu_ack[0] === 1'b1) begin
                got[nacks] = 1'b0;
                nacks++;
                ncpu++;
                if (ncpu == 6) cpu_req[0] = 1'b0;
            end else if (dbg_ack[0] === 1'b1) begin
                got[nacks] = 1'b1;
                nacks++;
                dbg_cyc = n;
                dbg_req[0] = 1'b0;
            end
            if (nacks >= 7) break;
            @(posedge clk);
        end
        cpu_req[0] = 1'b0;
        dbg_req[0] = 1'b0;
        checks++;
        if (got !== 7'b001_0000) begin
            errors++;
            $display("FAIL starve_order: got %b expected 0010000 (bit i = ack i from dbg)", got);
        end
        checks++;
        if (dbg_cyc !== 19) begin
            errors++;
            $display("FAIL starve_dbg_cycle: got %0d expected 19", dbg_cyc);
        end
        checks++;
        if (dbg_rdata[0] !== 32'hA5A5_0044) begin
            errors++;
            $display("FAIL starve_dbg_rdata: got %h expected a5a50044", dbg_rdata[0]);
        end
    endtask

    task automatic test_reject();
        int          lat;
        logic [31:0] rd;
        logic        e;
        bit          sb;
        int          rdc;
        int          wrc;
        do_access(0, 1'b0, 1'b0, 32'h22, 32'h0, lat, rd, e, sb, rdc, wrc);
        checks++;
        if (lat !== 1 || e !== 1'b1 || rd !== 32'h0 || rdc !== 0) begin
            errors++;
            $display("FAIL reject_misaligned: got lat=%0d err=%b rd=%h memrd=%0d expected 1 1 0 0",
                     lat, e, rd, rdc);
        end
        do_access(0, 1'b1, 1'b1, 32'h1FFD, 32'h1234_5678, lat, rd, e, sb, rdc, wrc);
        checks++;
        if (lat !== 1 || e !== 1'b1 || rd !== 32'h0 || wrc !== 0) begin
            errors++;
            $display("FAIL reject_dbg_store: got lat=%0d err=%b rd=%h memwr=%0d expected 1 1 0 0",
                     lat, e, rd, wrc);
        end
        do_access(0, 1'b0, 1'b0, 32'h2000, 32'h0, lat, rd, e, sb, rdc, wrc);
        checks++;
        if (lat !== 1 || e !== 1'b1 || rdc !== 0) begin
            errors++;
            $display("FAIL reject_range: got lat=%0d err=%b memrd=%0d expected 1 1 0",
                     lat, e, rdc);
        end
        do_access(0, 1'b1, 1'b0, 32'h1FFC, 32'h0, lat, rd, e, sb, rdc, wrc);
        checks++;
        if (lat !== 3 || e !== 1'b0 || rd !== 32'hA5A5_1FFC) begin
            errors++;
            $display("FAIL last_word: got lat=%0d err=%b rd=%h expected 3 0 a5a51ffc",
                     lat, e, rd);
        end
    endtask

    task automatic test_wait_sweep();
        int          lat;
        logic [31:0] rd;
        logic        e;
        bit          sb;
        int          rdc;
        int          wrc;
        do_access(1, 1'b0, 1'b0, 32'h30, 32'h0, lat, rd, e, sb, rdc, wrc);
        checks++;
        if (lat !== 2 || rdc !== 1 || rd !== 32'hA5A5_0030 || sb) begin
            errors++;
            $display("FAIL wait0: got lat=%0d memrd=%0d rd=%h stall_bad=%0d expected 2 1 a5a50030 0",
                     lat, rdc, rd, sb);
        end
        do_access(2, 1'b0, 1'b0, 32'h30, 32'h0, lat, rd, e, sb, rdc, wrc);
        checks++;
        if (lat !== 5 || rdc !== 4 || rd !== 32'hA5A5_0030 || sb) begin
            errors++;
            $display("FAIL wait3: got lat=%0d memrd=%0d rd=%h stall_bad=%0d expected 5 4 a5a50030 0",
                     lat, rdc, rd, sb);
        end
    endtask

    initial begin
        rst     = 1'b1;
        mem_clr = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cpu_req[k] = 1'b0; cpu_we[k] = 1'b0; cpu_addr[k] = '0; cpu_wdata[k] = '0;
            dbg_req[k] = 1'b0; dbg_we[k] = 1'b0; dbg_addr[k] = '0; dbg_wdata[k] = '0;
        end
        test_reset();
        test_store_load();
        test_simultaneous();
        test_starvation();
        test_reject();
        test_wait_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule
